// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard scoreboard.
//   sb_entry_t : one in-flight pipeline slot {v, wb, ld, dest}
//   SB_DEPTH   : number of shadowed stages (EX, MEM, WB)
//   REG_ZERO   : hard-wired zero register, never a hazard source
// REG_FILE_ADDR_LEN normally comes from defines.v; a fallback of 5 is provided
// so this package also builds stand-alone.
// -----------------------------------------------------------------------------
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif

package hazard_pkg;

   localparam int unsigned SB_DEPTH  = 3;
   localparam int unsigned SB_DEST_W = `REG_FILE_ADDR_LEN;

   // Slot indices into the shadow array
   localparam int unsigned IDX_EX  = 0;
   localparam int unsigned IDX_MEM = 1;
   localparam int unsigned IDX_WB  = 2;

   localparam logic [SB_DEST_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic                 v;     // slot holds a real instruction
      logic                 wb;    // instruction writes the register file
      logic                 ld;    // instruction is a load
      logic [SB_DEST_W-1:0] dest;  // destination register
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '0;

   // An entry that will actually produce a register value
   function automatic logic sb_is_writer(input sb_entry_t e);
      return e.v & e.wb;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Combinational RAW comparator for one shadowed pipeline stage.
// Ports:
//   i_entry   : shadow entry of the stage being compared
//   i_src1    : first ID-stage source register
//   i_src2    : second ID-stage source register
//   i_two_src : ID instruction actually reads i_src2
//   o_m1      : entry produces i_src1
//   o_m2      : entry produces i_src2 (only when i_two_src)
// -----------------------------------------------------------------------------
module sb_match
   import hazard_pkg::*;
(
   input  sb_entry_t            i_entry,
   input  logic [SB_DEST_W-1:0] i_src1,
   input  logic [SB_DEST_W-1:0] i_src2,
   input  logic                 i_two_src,
   output logic                 o_m1,
   output logic                 o_m2
);

   logic w_live;

   // Only valid writers to a non-zero register can create a dependency
   assign w_live = i_entry.v & i_entry.wb & (i_entry.dest != REG_ZERO);

   assign o_m1 = w_live & (i_entry.dest == i_src1);
   assign o_m2 = w_live & i_two_src & (i_entry.dest == i_src2);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Stall-decision side of the controller: shadows the EX/MEM/WB destination
// registers and raises hazard_detected on a read-after-write conflict with the
// instruction currently in ID.
// Build option: define HAZARD_FORWARDING_EN when forwarding paths exist; then
// only a load-use dependency on EX stalls (one cycle).
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   id_valid        : ID holds a real instruction
//   id_src1/id_src2 : ID source registers; id_two_src says src2 is read
//   id_dest         : ID destination register
//   id_wb_en        : ID instruction writes the register file
//   id_mem_r_en     : ID instruction is a load
//   hazard_detected : combinational stall request for IF/ID this cycle
//   inflight_cnt    : number of valid writers in EX/MEM/WB
//   stall_cnt       : saturating count of stalled cycles
// REG_ADDR_W is expected to equal hazard_pkg::SB_DEST_W.
// -----------------------------------------------------------------------------
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned STALL_CNT_W = 16,
   parameter int unsigned REG_ADDR_W  = `REG_FILE_ADDR_LEN
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [REG_ADDR_W-1:0]  id_src1,
   input  logic [REG_ADDR_W-1:0]  id_src2,
   input  logic                   id_two_src,
   input  logic [REG_ADDR_W-1:0]  id_dest,
   input  logic                   id_wb_en,
   input  logic                   id_mem_r_en,
   output logic                   hazard_detected,
   output logic [1:0]             inflight_cnt,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   sb_entry_t r_shadow [SB_DEPTH];
   sb_entry_t w_issue;

   logic [SB_DEST_W-1:0]   w_src1;
   logic [SB_DEST_W-1:0]   w_src2;
   logic                   w_ex_m1;
   logic                   w_ex_m2;
   logic                   w_mem_m1;
   logic                   w_mem_m2;
   logic                   w_ex_hit;
   logic                   w_mem_hit;
   logic [STALL_CNT_W-1:0] r_stall_cnt;
   logic                   w_unused;

   assign w_src1 = SB_DEST_W'(id_src1);
   assign w_src2 = SB_DEST_W'(id_src2);

   sb_match u_match_ex (
      .i_entry   (r_shadow[IDX_EX]),
      .i_src1    (w_src1),
      .i_src2    (w_src2),
      .i_two_src (id_two_src),
      .o_m1      (w_ex_m1),
      .o_m2      (w_ex_m2)
   );

   sb_match u_match_mem (
      .i_entry   (r_shadow[IDX_MEM]),
      .i_src1    (w_src1),
      .i_src2    (w_src2),
      .i_two_src (id_two_src),
      .o_m1      (w_mem_m1),
      .o_m2      (w_mem_m2)
   );

   assign w_ex_hit  = w_ex_m1 | w_ex_m2;
   assign w_mem_hit = w_mem_m1 | w_mem_m2;

   // WB never stalls: the register file writes before it reads in a cycle.
`ifdef HAZARD_FORWARDING_EN
   // Only a load still in EX has no value to forward yet.
   assign hazard_detected = id_valid & w_ex_hit & r_shadow[IDX_EX].ld;
   assign w_unused = ^{w_mem_hit, r_shadow[IDX_MEM].ld, r_shadow[IDX_WB].ld,
                       r_shadow[IDX_WB].dest};
`else
   assign hazard_detected = id_valid & (w_ex_hit | w_mem_hit);
   assign w_unused = ^{r_shadow[IDX_EX].ld, r_shadow[IDX_MEM].ld, r_shadow[IDX_WB].ld,
                       r_shadow[IDX_WB].dest};
`endif

   // A stalled or empty ID slot enters EX as a bubble, so a stalled
   // instruction is re-evaluated every cycle as its producer moves on.
   always_comb begin
      w_issue = SB_BUBBLE;
      if (id_valid && !hazard_detected) begin
         w_issue.v    = 1'b1;
         w_issue.wb   = id_wb_en;
         w_issue.ld   = id_mem_r_en;
         w_issue.dest = SB_DEST_W'(id_dest);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow[IDX_EX]  <= SB_BUBBLE;
         r_shadow[IDX_MEM] <= SB_BUBBLE;
         r_shadow[IDX_WB]  <= SB_BUBBLE;
      end else begin
         r_shadow[IDX_WB]  <= r_shadow[IDX_MEM];
         r_shadow[IDX_MEM] <= r_shadow[IDX_EX];
         r_shadow[IDX_EX]  <= w_issue;
      end
   end

   // Saturating: holds at all-ones instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (hazard_detected && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;

   assign inflight_cnt = {1'b0, sb_is_writer(r_shadow[IDX_EX])}
                       + {1'b0, sb_is_writer(r_shadow[IDX_MEM])}
                       + {1'b0, sb_is_writer(r_shadow[IDX_WB])};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed stimulus pushes hand-computed expectations into a queue; a monitor
// on the falling edge pops one per cycle and compares the DUT outputs.
// A second instance with a 4-bit stall counter shares the stimulus so that
// counter saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam int unsigned SAT_MAX = 15;

   typedef struct {
      bit          hz;
      logic [1:0]  inf;
      int unsigned st;
      string       tag;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_src1;
   logic [4:0]  id_src2;
   logic        id_two_src;
   logic [4:0]  id_dest;
   logic        id_wb_en;
   logic        id_mem_r_en;
   logic        hazard_detected;
   logic [1:0]  inflight_cnt;
   logic [15:0] stall_cnt;
   logic        sat_hazard;
   logic [1:0]  sat_inflight;
   logic [3:0]  sat_stall;

   exp_t        q[$];
   exp_t        m_e;
   int unsigned exp_stall;
   int          total;
   int          bad;

   hazard_scoreboard u_dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_src1         (id_src1),
      .id_src2         (id_src2),
      .id_two_src      (id_two_src),
      .id_dest         (id_dest),
      .id_wb_en        (id_wb_en),
      .id_mem_r_en     (id_mem_r_en),
      .hazard_detected (hazard_detected),
      .inflight_cnt    (inflight_cnt),
      .stall_cnt       (stall_cnt)
   );

   hazard_scoreboard #(.STALL_CNT_W(4)) u_dut_sat (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_src1         (id_src1),
      .id_src2         (id_src2),
      .id_two_src      (id_two_src),
      .id_dest         (id_dest),
      .id_wb_en        (id_wb_en),
      .id_mem_r_en     (id_mem_r_en),
      .hazard_detected (sat_hazard),
      .inflight_cnt    (sat_inflight),
      .stall_cnt       (sat_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input string tag, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s [%s] at %0t: got %0d expected %0d", name, tag, $time, act, req);
      end
   endtask

   // Monitor: outputs are valid every cycle, one expectation per cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         m_e = q.pop_front();
         chk("hazard", m_e.tag, int'(hazard_detected), int'(m_e.hz));
         chk("inflight", m_e.tag, int'(inflight_cnt), int'(m_e.inf));
         chk("stall_cnt", m_e.tag, int'(stall_cnt), int'(m_e.st));
         chk("stall_cnt_sat", m_e.tag, int'(sat_stall),
             int'((m_e.st > SAT_MAX) ? SAT_MAX : m_e.st));
         chk("hazard_sat", m_e.tag, int'(sat_hazard), int'(m_e.hz));
      end
   end

   task automatic drive(input bit r, input bit v, input logic [4:0] s1, input logic [4:0] s2,
                        input bit two, input logic [4:0] d, input bit wb, input bit ld,
                        input bit ehz, input logic [1:0] einf, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      rst         = r;
      id_valid    = v;
      id_src1     = s1;
      id_src2     = s2;
      id_two_src  = two;
      id_dest     = d;
      id_wb_en    = wb;
      id_mem_r_en = ld;
      if (r) exp_stall = 0;
      e.hz  = ehz;
      e.inf = einf;
      e.st  = exp_stall;
      e.tag = tag;
      q.push_back(e);
      if (ehz) exp_stall++;
   endtask

   task automatic bubble(input logic [1:0] einf, input string tag);
      drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, einf, tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         sat_hz;
      logic [1:0] sat_inf;
      total       = 0;
      bad         = 0;
      exp_stall   = 0;
      rst         = 1'b1;
      id_valid    = 1'b0;
      id_src1     = '0;
      id_src2     = '0;
      id_two_src  = 1'b0;
      id_dest     = '0;
      id_wb_en    = 1'b0;
      id_mem_r_en = 1'b0;

      // Reset: a writer offered during reset must not enter the shadow
      drive(1, 1, 5'd3, 5'd0, 0, 5'd3, 1, 0, 0, 2'd0, "reset");
      drive(1, 1, 5'd3, 5'd0, 0, 5'd3, 1, 0, 0, 2'd0, "reset2");

      // ADD r3 then a reader of r3
      drive(0, 1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0, 2'd0, "add_r3");
      drive(0, 1, 5'd3, 5'd0, 1, 5'd6, 1, 0, !FWD, 2'd1, "raw_ex");
      drive(0, 1, 5'd3, 5'd0, 1, 5'd6, 1, 0, !FWD, FWD ? 2'd2 : 2'd1, "raw_mem");
      drive(0, 1, 5'd3, 5'd0, 1, 5'd6, 1, 0, 0, FWD ? 2'd3 : 2'd1, "raw_release");
      bubble(FWD ? 2'd3 : 2'd1, "flush_a1");
      bubble(FWD ? 2'd2 : 2'd1, "flush_a2");
      bubble(2'd1, "flush_a3");

      // LD r4 then a reader of r4
      drive(0, 1, 5'd1, 5'd0, 0, 5'd4, 1, 1, 0, 2'd0, "ld_r4");
      drive(0, 1, 5'd4, 5'd0, 0, 5'd7, 1, 0, 1, 2'd1, "loaduse_ex");
      drive(0, 1, 5'd4, 5'd0, 0, 5'd7, 1, 0, !FWD, 2'd1, "loaduse_mem");
      drive(0, 1, 5'd4, 5'd0, 0, 5'd7, 1, 0, 0, FWD ? 2'd2 : 2'd1, "loaduse_rel");
      bubble(FWD ? 2'd2 : 2'd1, "flush_b1");
      bubble(FWD ? 2'd2 : 2'd1, "flush_b2");
      bubble(2'd1, "flush_b3");

      // r0 writer never matches; a store (wb=0) never matches
      drive(0, 1, 5'd1, 5'd0, 0, 5'd0, 1, 0, 0, 2'd0, "wr_r0");
      drive(0, 1, 5'd0, 5'd0, 1, 5'd8, 0, 0, 0, 2'd1, "rd_r0");
      drive(0, 1, 5'd1, 5'd0, 0, 5'd5, 0, 0, 0, 2'd1, "st_r5");
      drive(0, 1, 5'd5, 5'd0, 0, 5'd9, 1, 0, 0, 2'd1, "rd_r5");
      bubble(2'd1, "flush_c1");
      bubble(2'd1, "flush_c2");
      bubble(2'd1, "flush_c3");

      // id_two_src gating of src2, then id_valid=0 against a live match
      drive(0, 1, 5'd1, 5'd0, 0, 5'd7, 1, 1, 0, 2'd0, "ld_r7");
      drive(0, 1, 5'd2, 5'd7, 0, 5'd10, 0, 0, 0, 2'd1, "src2_ignored");
      drive(0, 1, 5'd1, 5'd0, 0, 5'd7, 1, 1, 0, 2'd1, "ld_r7_again");
      drive(0, 1, 5'd2, 5'd7, 1, 5'd11, 1, 0, 1, 2'd2, "src2_used");
      drive(0, 0, 5'd7, 5'd7, 1, 5'd11, 1, 0, 0, 2'd1, "invalid_id");
      bubble(2'd1, "flush_d1");
      bubble(2'd0, "flush_d2");

      // Reset asserted during a stall cycle
      drive(0, 1, 5'd1, 5'd0, 0, 5'd3, 1, 1, 0, 2'd0, "ld_r3");
      drive(0, 1, 5'd3, 5'd0, 0, 5'd12, 1, 0, 1, 2'd1, "pre_rst_stall");
      drive(1, 1, 5'd3, 5'd0, 0, 5'd12, 1, 0, 0, 2'd0, "rst_mid_stall");
      drive(1, 1, 5'd3, 5'd0, 0, 5'd12, 1, 0, 0, 2'd0, "rst_hold");
      bubble(2'd0, "rst_release");
      drive(0, 1, 5'd3, 5'd0, 0, 5'd12, 1, 0, 0, 2'd0, "post_rst_rd");
      bubble(2'd1, "flush_e1");
      bubble(2'd1, "flush_e2");
      bubble(2'd1, "flush_e3");

      // Self-dependent load held in ID: repeated stalls saturate the 4-bit counter
      for (int k = 0; k < 40; k++) begin
         if (FWD) begin
            sat_hz  = (k % 2) == 1;
            sat_inf = (k == 0) ? 2'd0 : ((k >= 3 && (k % 2) == 1) ? 2'd2 : 2'd1);
         end else begin
            sat_hz  = (k % 3) != 0;
            sat_inf = (k == 0) ? 2'd0 : 2'd1;
         end
         drive(0, 1, 5'd3, 5'd0, 0, 5'd3, 1, 1, sat_hz, sat_inf, "saturate");
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
